// File: rtl/backend_multich_cfg.sv
// Serial-link backend: receives addr/data/parity frames on sclk/sdin and drives
// per-channel gain/resetb plus the VCO resetb, with parity, timeout and soft reset.
module backend_multich_cfg #(
  parameter int unsigned NCH       = 2,
  parameter int unsigned GAIN_W    = 3,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned READY_DLY = 16
) (
  input  logic                  i_clk,
  input  logic                  i_resetAll,
  input  logic                  i_sclk,
  input  logic                  i_sdin,
  output logic                  o_ready,
  output logic [NCH*GAIN_W-1:0] o_gain,
  output logic [NCH-1:0]        o_resetb,
  output logic                  o_resetbvco,
  output logic                  o_frame_err
);

  localparam int unsigned F    = ADDR_W + DATA_W + 1;
  localparam int unsigned BC_W = $clog2(F + 1);
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned RD_W = $clog2(READY_DLY + 1);
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NCH);

  typedef enum logic [1:0] {WAIT_RDY, IDLE, SHIFT, COMMIT} state_e;

  state_e                state_q, state_d;
  logic                  sclk_s1_q, sclk_s2_q, sclk_prev_q, sdin_s1_q, sdin_s2_q;
  logic [BC_W-1:0]       bitcnt_q, bitcnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [RD_W-1:0]       rdy_cnt_q, rdy_cnt_d;
  logic [F-1:0]          sr_q, sr_d;
  logic [NCH*GAIN_W-1:0] gain_q, gain_d;
  logic [NCH-1:0]        rstb_q, rstb_d;
  logic                  vco_q, vco_d;
  logic                  err_q, err_d;
  logic                  ready_q, ready_d;
  logic                  edge_det;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     data;

  assign edge_det = sclk_s2_q & ~sclk_prev_q;
  assign addr     = sr_q[F-1 -: ADDR_W];
  assign data     = sr_q[DATA_W:1];

  always_ff @(posedge i_clk or posedge i_resetAll) begin
    if (i_resetAll) begin
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      sdin_s1_q   <= 1'b0;
      sdin_s2_q   <= 1'b0;
      state_q     <= WAIT_RDY;
      bitcnt_q    <= '0;
      to_cnt_q    <= '0;
      rdy_cnt_q   <= '0;
      sr_q        <= '0;
      gain_q      <= '0;
      rstb_q      <= '0;
      vco_q       <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      sclk_s1_q   <= i_sclk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_prev_q <= sclk_s2_q;
      sdin_s1_q   <= i_sdin;
      sdin_s2_q   <= sdin_s1_q;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      to_cnt_q    <= to_cnt_d;
      rdy_cnt_q   <= rdy_cnt_d;
      sr_q        <= sr_d;
      gain_q      <= gain_d;
      rstb_q      <= rstb_d;
      vco_q       <= vco_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    to_cnt_d  = to_cnt_q;
    rdy_cnt_d = rdy_cnt_q;
    sr_d      = sr_q;
    gain_d    = gain_q;
    rstb_d    = rstb_q;
    vco_d     = vco_q;
    err_d     = 1'b0;
    unique case (state_q)
      WAIT_RDY: begin
        if (rdy_cnt_q == RD_W'(READY_DLY - 1)) state_d = IDLE;
        else rdy_cnt_d = rdy_cnt_q + 1'b1;
      end
      IDLE: begin
        if (edge_det) begin
          sr_d     = {sr_q[F-2:0], sdin_s2_q};
          bitcnt_d = BC_W'(1);
          to_cnt_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (edge_det) begin
          sr_d     = {sr_q[F-2:0], sdin_s2_q};
          bitcnt_d = bitcnt_q + 1'b1;
          to_cnt_d = '0;
          if (bitcnt_q == BC_W'(F - 1)) state_d = COMMIT;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          err_d    = 1'b1;
          bitcnt_d = '0;
          to_cnt_d = '0;
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      COMMIT: begin
        state_d  = IDLE;
        bitcnt_d = '0;
        if (^sr_q) begin
          err_d = 1'b1;
        end else if (addr == CTRL_ADDR) begin
          // Soft reset dominates the VCO bit in the same command.
          if (data[1]) begin
            gain_d = '0;
            rstb_d = '0;
            vco_d  = 1'b0;
          end else begin
            vco_d  = data[0];
          end
        end else if (addr > CTRL_ADDR) begin
          err_d = 1'b1;
        end else begin
          for (int unsigned k = 0; k < NCH; k++) begin
            if (addr == ADDR_W'(k)) begin
              gain_d[k*GAIN_W +: GAIN_W] = data[GAIN_W-1:0];
              rstb_d[k]                  = data[GAIN_W];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_d     = (state_d == IDLE);
  assign o_ready     = ready_q;
  assign o_gain      = gain_q;
  assign o_resetb    = rstb_q;
  assign o_resetbvco = vco_q;
  assign o_frame_err = err_q;

endmodule

// File: tb/tb_backend_multich_cfg.sv
// Scoreboard bench for backend_multich_cfg: frames are modelled when sent and
// checked against the registered outputs once the commit has settled.
module tb_backend_multich_cfg;

  localparam int NCH = 2, GAIN_W = 3, ADDR_W = 4, DATA_W = 8;

  logic                  clk = 1'b0;
  logic                  rst, sclk, sdin;
  logic                  o_ready, o_resetbvco, o_frame_err;
  logic [NCH*GAIN_W-1:0] o_gain;
  logic [NCH-1:0]        o_resetb;

  always #5 clk = ~clk;

  backend_multich_cfg #(
    .NCH(NCH), .GAIN_W(GAIN_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .TIMEOUT(64), .READY_DLY(16)
  ) dut (
    .i_clk(clk), .i_resetAll(rst), .i_sclk(sclk), .i_sdin(sdin),
    .o_ready(o_ready), .o_gain(o_gain), .o_resetb(o_resetb),
    .o_resetbvco(o_resetbvco), .o_frame_err(o_frame_err)
  );

  typedef struct {
    logic [5:0] gain;
    logic [1:0] rstb;
    logic       vco;
    int         err;
    int         err_base;
  } exp_t;

  exp_t       sb[$];
  logic [5:0] m_gain;
  logic [1:0] m_rstb;
  logic       m_vco;
  int         n_cmp = 0, n_bad = 0;
  int         err_seen = 0;

  always @(posedge clk) if (o_frame_err === 1'b1) err_seen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] mk(input logic [3:0] a, input logic [7:0] d, input logic flip);
    logic p;
    p = ^{a, d};
    return {a, d, p ^ flip};
  endfunction

  task automatic send_bits(input logic [12:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) sdin = fr[12-i];
      repeat (2) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_gain"}, 32'(o_gain), 32'(m_gain));
    chk({tag, "_rstb"}, 32'(o_resetb), 32'(m_rstb));
    chk({tag, "_vco"}, 32'(o_resetbvco), 32'(m_vco));
  endtask

  task automatic send_frame(input string tag, input logic [12:0] fr);
    exp_t       e;
    logic [3:0] a;
    logic [7:0] d;
    a = fr[12:9];
    d = fr[8:1];
    e.err = 0;
    if (^fr) e.err = 1;
    else if (a < 4'd2) begin
      m_gain[a*3 +: 3] = d[2:0];
      m_rstb[a[0]]     = d[3];
    end else if (a == 4'd2) begin
      if (d[1]) begin
        m_gain = '0;
        m_rstb = '0;
        m_vco  = 1'b0;
      end else m_vco = d[0];
    end else e.err = 1;
    e.gain = m_gain;
    e.rstb = m_rstb;
    e.vco  = m_vco;
    e.err_base = err_seen;
    sb.push_back(e);
    send_bits(fr, 13);
    repeat (6) @(negedge clk);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_gain"}, 32'(o_gain), 32'(e.gain));
      chk({tag, "_rstb"}, 32'(o_resetb), 32'(e.rstb));
      chk({tag, "_vco"}, 32'(o_resetbvco), 32'(e.vco));
      chk({tag, "_errs"}, 32'(err_seen - e.err_base), 32'(e.err));
      chk({tag, "_ready"}, 32'(o_ready), 32'd1);
    end
  endtask

  task automatic wait_ready(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (o_ready === 1'b1) return;
      @(negedge clk);
    end
    chk({tag, "_ready_timeout"}, 32'(o_ready), 32'd1);
  endtask

  initial begin
    int base;
    rst = 1'b1; sclk = 1'b0; sdin = 1'b0;
    m_gain = '0; m_rstb = '0; m_vco = 1'b0;
    repeat (3) @(negedge clk);
    check_state("rst");
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_err", 32'(o_frame_err), 32'd0);

    // Release, toggling sclk early in the wait window; those edges must be ignored.
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      sdin = 1'b1;
      if (i < 8) sclk = (i % 2 == 0);
      else sclk = 1'b0;
    end
    chk("wait_ready_low", 32'(o_ready), 32'd0);
    wait_ready("wait", 4);
    check_state("wait");

    send_frame("ch0", mk(4'd0, 8'b0000_1101, 1'b0));
    send_frame("ch1", mk(4'd1, 8'b0000_1010, 1'b0));
    send_frame("vco", mk(4'd2, 8'b0000_0001, 1'b0));
    send_frame("ch0b", mk(4'd0, 8'b0000_0110, 1'b0));
    send_frame("soft", mk(4'd2, 8'b0000_0011, 1'b0));
    send_frame("ch0c", mk(4'd0, 8'b0000_1101, 1'b0));
    send_frame("par", mk(4'd0, 8'b0000_0101, 1'b1));
    send_frame("badaddr", mk(4'd5, 8'b0000_0000, 1'b0));
    send_frame("vco1", mk(4'd2, 8'b0000_0001, 1'b0));

    base = err_seen;
    send_bits(mk(4'd0, 8'b0000_1111, 1'b0), 7);
    repeat (70) @(negedge clk);
    chk("to_errs", 32'(err_seen - base), 32'd1);
    chk("to_ready", 32'(o_ready), 32'd1);
    check_state("to_hold");
    send_frame("after_to", mk(4'd1, 8'b0000_1111, 1'b0));

    send_bits(mk(4'd0, 8'b0000_1110, 1'b0), 6);
    rst = 1'b1;
    #1;
    m_gain = '0; m_rstb = '0; m_vco = 1'b0;
    check_state("midrst");
    chk("midrst_ready", 32'(o_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ready("midrst", 30);
    send_frame("after_rst", mk(4'd0, 8'b0000_1110, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
